// File: rtl/sync_pkg.sv
// Shared types and default widths for the clocked sync fork/join family.
package sync_pkg;

    typedef enum logic {
        FORK_EMPTY,
        FORK_FULL
    } fork_state_e;

    localparam int unsigned DEF_NUM_OUT = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/sync_fork_done_tree.sv
// Per-branch completion vector and its AND reduction; the clocked stand-in for a
// C-element acknowledge tree, shared by fork and join style blocks.
module sync_fork_done_tree #(
    parameter int unsigned NUM_OUT = 4
) (
    input  logic [NUM_OUT-1:0] taken_i,
    input  logic [NUM_OUT-1:0] valid_i,
    input  logic [NUM_OUT-1:0] ready_i,
    output logic [NUM_OUT-1:0] done_o,
    output logic               all_done_o
);

    always_comb begin
        done_o     = taken_i | (valid_i & ready_i);
        all_done_o = &done_o;
    end

endmodule

// File: rtl/sync_fork_n.sv
// N-way valid/ready fork with a single-entry buffer and per-branch completion tracking.
// Optional per-word branch mask enabled by defining SYNC_FORK_MASK_EN.
module sync_fork_n
    import sync_pkg::*;
#(
    parameter int unsigned NUM_OUT = DEF_NUM_OUT,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic [NUM_OUT-1:0] out_valid_o,
    input  logic [NUM_OUT-1:0] out_ready_i,
`ifdef SYNC_FORK_MASK_EN
    input  logic [NUM_OUT-1:0] out_mask_i,
`endif
    output logic [DATA_W-1:0]  out_data_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   xfer_cnt_o
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    fork_state_e        state_q, state_d;
    logic [NUM_OUT-1:0] taken_q, taken_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_OUT-1:0] done;
    logic               all_done;
    logic               accept;
    logic [NUM_OUT-1:0] taken_init;

    // Masked-off branches start out already taken so they never raise valid.
`ifdef SYNC_FORK_MASK_EN
    assign taken_init = ~out_mask_i;
`else
    assign taken_init = '0;
`endif

    sync_fork_done_tree #(
        .NUM_OUT (NUM_OUT)
    ) u_done_tree (
        .taken_i    (taken_q),
        .valid_i    (out_valid_o),
        .ready_i    (out_ready_i),
        .done_o     (done),
        .all_done_o (all_done)
    );

    always_comb begin
        out_valid_o = (state_q == FORK_FULL) ? ~taken_q : '0;
        // out_ready_i reaches in_ready_o combinationally to allow back-to-back words.
        in_ready_o  = (state_q == FORK_EMPTY) || all_done;
        accept      = in_valid_i && in_ready_o;
        out_data_o  = data_q;
        busy_o      = (state_q == FORK_FULL);
        xfer_cnt_o  = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            FORK_EMPTY: begin
                if (accept) begin
                    state_d = FORK_FULL;
                    taken_d = taken_init;
                    data_d  = in_data_i;
                end
            end
            FORK_FULL: begin
                if (all_done) begin
                    cnt_d = cnt_q + CntOne;
                    if (accept) begin
                        taken_d = taken_init;
                        data_d  = in_data_i;
                    end else begin
                        state_d = FORK_EMPTY;
                        taken_d = '0;
                    end
                end else begin
                    taken_d = done;
                end
            end
            default: begin
                state_d = FORK_EMPTY;
                taken_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FORK_EMPTY;
            taken_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sync_fork_n.sv
// Self-checking bench for sync_fork_n: directed scenarios plus random traffic against
// a model that tracks the set of branches still owed the current word.
module tb_sync_fork_n;

    localparam int unsigned NO = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [NO-1:0] out_valid;
    logic [NO-1:0] out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [CW-1:0] xfer_cnt;
`ifdef SYNC_FORK_MASK_EN
    logic [NO-1:0] mask;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit            m_full;
    logic [NO-1:0] m_owed;
    logic [DW-1:0] m_word;
    int            m_cnt;

    sync_fork_n #(
        .NUM_OUT (NO),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef SYNC_FORK_MASK_EN
        .out_mask_i  (mask),
`endif
        .out_data_o  (out_data),
        .busy_o      (busy),
        .xfer_cnt_o  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NO-1:0] eff_mask();
`ifdef SYNC_FORK_MASK_EN
        return mask;
`else
        return '1;
`endif
    endfunction

    function automatic bit exp_in_ready();
        return !m_full || ((m_owed & ~out_ready) == '0);
    endfunction

    // Compare every output against the model, then advance one clock.
    task automatic tick();
        bit fire;
        #2;
        check_eq("out_valid", 64'(out_valid), 64'(m_full ? m_owed : '0));
        check_eq("in_ready",  64'(in_ready),  64'(exp_in_ready()));
        check_eq("out_data",  64'(out_data),  64'(m_word));
        check_eq("busy",      64'(busy),      64'(m_full));
        check_eq("xfer_cnt",  64'(xfer_cnt),  64'(m_cnt));
        fire = in_valid && exp_in_ready();
        @(posedge clk);
        if (rst) begin
            m_full = 0;
            m_owed = '0;
            m_word = '0;
            m_cnt  = 0;
        end else begin
            if (m_full) begin
                if ((m_owed & ~out_ready) == '0) begin
                    m_cnt  = (m_cnt + 1) % (1 << CW);
                    m_full = 0;
                    m_owed = '0;
                end else begin
                    m_owed = m_owed & ~out_ready;
                end
            end
            if (fire) begin
                m_full = 1;
                m_word = in_data;
                m_owed = eff_mask();
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NO-1:0] r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_0001;
        out_ready = '0;
`ifdef SYNC_FORK_MASK_EN
        mask      = '1;
`endif
        m_full = 0;
        m_owed = '0;
        m_word = '0;
        m_cnt  = 0;

        // Reset held two cycles with in_valid high
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'h0);
        check_eq("rst_ready", 64'(in_ready), 64'h1);
        check_eq("rst_busy",  64'(busy), 64'h0);
        check_eq("rst_cnt",   64'(xfer_cnt), 64'h0);

        // Lockstep stream
        drive(1'b1, 32'h11, 4'hF);
        tick();
        drive(1'b1, 32'h22, 4'hF);
        check_eq("lock_valid1", 64'(out_valid), 64'hF);
        check_eq("lock_data1",  64'(out_data), 64'h11);
        check_eq("lock_ready1", 64'(in_ready), 64'h1);
        tick();
        drive(1'b1, 32'h33, 4'hF);
        check_eq("lock_data2",  64'(out_data), 64'h22);
        check_eq("lock_ready2", 64'(in_ready), 64'h1);
        tick();
        drive(1'b0, 32'h0, 4'hF);
        check_eq("lock_data3",  64'(out_data), 64'h33);
        tick();
        check_eq("lock_cnt", 64'(xfer_cnt), 64'h3);

        // Staggered completion
        drive(1'b1, 32'hA5, 4'h0);
        tick();
        drive(1'b0, 32'h0, 4'b0001);
        check_eq("stag_v0", 64'(out_valid), 64'hF);
        check_eq("stag_r0", 64'(in_ready), 64'h0);
        tick();
        drive(1'b0, 32'h0, 4'b0010);
        check_eq("stag_v1", 64'(out_valid), 64'hE);
        check_eq("stag_r1", 64'(in_ready), 64'h0);
        tick();
        drive(1'b0, 32'h0, 4'b0100);
        check_eq("stag_v2", 64'(out_valid), 64'hC);
        check_eq("stag_d2", 64'(out_data), 64'hA5);
        tick();
        drive(1'b0, 32'h0, 4'b1000);
        check_eq("stag_v3", 64'(out_valid), 64'h8);
        check_eq("stag_r3", 64'(in_ready), 64'h1);
        check_eq("stag_d3", 64'(out_data), 64'hA5);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        check_eq("stag_v4", 64'(out_valid), 64'h0);
        check_eq("stag_cnt", 64'(xfer_cnt), 64'h4);
        tick();

        // Stall on branch 2, then back-to-back accept of the queued word
        drive(1'b1, 32'h1234, 4'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hBEEF, 4'b1011);
            check_eq("stall_ready", 64'(in_ready), 64'h0);
            tick();
        end
        drive(1'b1, 32'hBEEF, 4'b0100);
        check_eq("stall_valid", 64'(out_valid), 64'h4);
        check_eq("b2b_ready", 64'(in_ready), 64'h1);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        check_eq("b2b_data",  64'(out_data), 64'hBEEF);
        check_eq("b2b_valid", 64'(out_valid), 64'hF);
        tick();
        drive(1'b0, 32'h0, 4'hF);
        tick();

        // Counter wrap: clear, then 16 transactions
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i + 1), 4'hF);
            tick();
        end
        drive(1'b0, 32'h0, 4'hF);
        tick();
        check_eq("wrap_cnt", 64'(xfer_cnt), 64'h0);

        // Reset with a partially delivered word
        drive(1'b1, 32'h5A5A, 4'h0);
        tick();
        drive(1'b0, 32'h0, 4'b1001);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        check_eq("mid_valid", 64'(out_valid), 64'h6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(out_valid), 64'h0);
        check_eq("mid_rst_cnt",   64'(xfer_cnt), 64'h0);
        check_eq("mid_rst_busy",  64'(busy), 64'h0);
        check_eq("mid_rst_data",  64'(out_data), 64'h0);

`ifdef SYNC_FORK_MASK_EN
        // Partial mask: only branches 0 and 2 are served
        mask = 4'b0101;
        drive(1'b1, 32'h77, 4'h0);
        tick();
        mask = 4'hF;
        drive(1'b0, 32'h0, 4'b0001);
        check_eq("mask_valid", 64'(out_valid), 64'h5);
        check_eq("mask_ready0", 64'(in_ready), 64'h0);
        tick();
        drive(1'b0, 32'h0, 4'b0100);
        check_eq("mask_valid2", 64'(out_valid), 64'h4);
        check_eq("mask_ready2", 64'(in_ready), 64'h1);
        tick();
        check_eq("mask_cnt", 64'(xfer_cnt), 64'h1);

        // Empty mask: counted without any valid
        mask = 4'h0;
        drive(1'b1, 32'h88, 4'h0);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        check_eq("mask0_valid", 64'(out_valid), 64'h0);
        check_eq("mask0_ready", 64'(in_ready), 64'h1);
        tick();
        check_eq("mask0_cnt", 64'(xfer_cnt), 64'h2);
        mask = 4'hF;
`endif

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15) | ($urandom_range(0, 1) ? 15 : 0));
`ifdef SYNC_FORK_MASK_EN
            mask      = 4'($urandom_range(0, 15));
`endif
            #1;
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 4'hF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fork_n.md
Name: sync_fork_n

Overview:
- Clocked, parametrised N-way fork for valid/ready channels.
- Synchronous successor of the 4-way asynchronous C-element fork in the sync library.
- Holds one data word in a single-entry buffer and broadcasts it to NUM_OUT consumers.
- Tracks per-branch completion, the clocked equivalent of the C-element acknowledge tree. Accepts the next word only when every branch has taken the current one, at full throughput of one word per cycle.

Parameters:
- NUM_OUT, 4, number of output branches (>=2)
- DATA_W, 32, payload width in bits
- CNT_W, 16, width of completed-transaction counter

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous active-high reset
- in_valid_i  input  1  upstream word valid
- in_ready_o  output  1  fork can accept a word this cycle
- in_data_i  input  DATA_W  upstream payload
- out_valid_o  output  NUM_OUT  per-branch valid
- out_ready_i  input  NUM_OUT  per-branch ready
- out_data_o  output  DATA_W  buffered payload, shared by all branches
- busy_o  output  1  buffer holds a word not yet taken by all branches
- xfer_cnt_o  output  CNT_W  count of fully completed fork transactions

Behaviour:
- Reset is synchronous and active-high; there is one clock. Reset values:
  - full=0, taken=0, data register=0, xfer_cnt_o=0
  - hence out_valid_o=0, busy_o=0, in_ready_o=1
- States: EMPTY (full=0) and FULL (full=1).
- out_valid_o[i] = full & ~taken[i]. Combinational from registers, no path from out_ready_i.
- done_i = taken[i] | (out_valid_o[i] & out_ready_i[i]); all_done = AND of done over all i.
- in_ready_o = ~full | all_done. This is a combinational out_ready_i -> in_ready_o path and is intentional, for full throughput.
- Accept: in_valid_i & in_ready_o. Effects:
  - data register <= in_data_i; full <= 1; taken <= 0 (see optional feature).
  - Latency from accept to out_valid_o asserted: 1 cycle.
- FULL and not all_done: taken[i] <= done_i; data held stable; in_valid_i ignored.
- FULL and all_done:
  - the transaction completes and xfer_cnt_o increments by 1, wrapping modulo 2^CNT_W;
  - if accepting in the same cycle: reload data, clear taken, stay FULL (back-to-back);
  - else: full <= 0.
- A branch that has taken the word keeps out_valid_o[i]=0 until the next word, regardless of out_ready_i.
- out_ready_i while out_valid_o[i]=0 has no effect.
- Simultaneous completion on all branches in the first FULL cycle completes the transaction in that cycle.
- busy_o = full.
- Reset mid-transaction: buffer discarded, taken cleared, counter cleared. No partial delivery is replayed.
- in_data_i is sampled only on accept.

Optional Feature:
- Macro: SYNC_FORK_MASK_EN.
- Enabled:
  - adds input out_mask_i [NUM_OUT], sampled on accept;
  - taken <= ~out_mask_i, so masked branches never assert valid and count as done;
  - all-zero mask: word completes in the first FULL cycle, is counted, and never appears on any valid.
- Disabled: port absent; behaviour as if out_mask_i were all ones.

Decomposition:
- Package sync_pkg:
  - typedef enum logic {FORK_EMPTY, FORK_FULL} fork_state_e
  - localparam default widths shared with join/fork blocks
- Sub-module sync_fork_done_tree: computes the done vector and the all_done reduction from taken, out_valid and out_ready. It is the clocked replacement of the C-element tree and is reusable by a future sync_join_n.

Test Plan:
- Reset: assert rst_i 2 cycles while in_valid_i=1 -> out_valid_o=0, in_ready_o=1, xfer_cnt_o=0, busy_o=0.
- Lockstep: NUM_OUT=4, all out_ready_i=1, stream 0x11,0x22,0x33 on consecutive cycles:
  - each word visible 1 cycle after accept with out_valid_o=4'hF;
  - in_ready_o stays 1 throughout;
  - xfer_cnt_o reaches 3.
- Staggered: word 0xA5, out_ready_i pulses branch 0,1,2,3 one per cycle:
  - out_valid_o steps F->E->C->8->0;
  - in_ready_o=1 only in the branch-3 cycle;
  - data stable 0xA5 throughout.
- Stall and back-to-back: branch 2 held not ready 5 cycles with in_valid_i=1 (0xBEEF queued) -> 0xBEEF is not accepted; it is accepted in the same cycle branch 2 completes; no idle cycle.
- Wrap and mid-reset:
  - CNT_W=4, 16 transactions -> xfer_cnt_o wraps to 0;
  - rst_i with out_valid_o=4'h6 pending -> next cycle all outputs 0, counter 0.
- SYNC_FORK_MASK_EN:
  - mask 4'b0101 -> only out_valid_o[0],[2] assert; completion after those two;
  - mask 4'b0000 -> xfer_cnt_o increments with no valid ever asserted.
